sap1_controller: RTL and testbench

SAP1_CONTROLLER -- requirements
Module: sap1_controller

---
 rtl/sap1_pkg.sv | 44 ++++
 rtl/sap1_ring_counter.sv | 48 ++++
 rtl/sap1_controller.sv | 102 ++++++++++
 tb/tb_sap1_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 opcodes, ALU op codes and T-state one-hot encoding
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  function automatic logic is_alu_opcode(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - T1..T6 ring with run hold, halt freeze and sync reset
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       halt_req,
  output logic [5:0] t_state,
  output logic       halted
);

  t_state_e state, state_next;
  logic     halted_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // A halt request freezes the ring in place instead of advancing it.
  always_comb begin
    state_next  = state;
    halted_next = halted;
    if (run && !halted) begin
      if (halt_req) begin
        halted_next = 1'b1;
      end else begin
        case (state)
          T1:      state_next = T2;
          T2:      state_next = T3;
          T3:      state_next = T4;
          T4:      state_next = T5;
          T5:      state_next = T6;
          default: state_next = T1;
        endcase
      end
    end
  end

  assign t_state = state;

endmodule

// File: rtl/sap1_controller.sv
// rtl/sap1_controller.sv - SAP-1 control sequencer; SAP1_CTRL_JMP_EN enables JMP (0110)
module sap1_controller
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] alu_op
);

  logic halt_req;
  logic active;

  assign halt_req = (t_state == T4) && (opcode == OP_HLT);
  assign active   = !rst && run && !halted;

  sap1_ring_counter u_ring (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .halt_req (halt_req),
    .t_state  (t_state),
    .halted   (halted)
  );

  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;
    alu_op   = ALU_ADD;
    if (active) begin
      case (t_state)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || is_alu_opcode(opcode)) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
`ifdef SAP1_CTRL_JMP_EN
          else if (opcode == OP_JMP) begin
            ir_out  = 1'b1;
            pc_load = 1'b1;
          end
`endif
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (is_alu_opcode(opcode)) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
          end
        end
        T6: begin
          if (is_alu_opcode(opcode)) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_op  = alu_op_of(opcode);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// tb/tb_sap1_controller.sv - vector-table bench for sap1_controller with expected-value queue
module tb_sap1_controller;

  localparam logic [12:0] PC_INC   = 13'h1000;
  localparam logic [12:0] PC_OUT   = 13'h0800;
  localparam logic [12:0] PC_LOAD  = 13'h0400;
  localparam logic [12:0] MAR_LOAD = 13'h0200;
  localparam logic [12:0] RAM_OUT  = 13'h0100;
  localparam logic [12:0] IR_LOAD  = 13'h0080;
  localparam logic [12:0] IR_OUT   = 13'h0040;
  localparam logic [12:0] A_LOAD   = 13'h0020;
  localparam logic [12:0] A_OUT    = 13'h0010;
  localparam logic [12:0] B_LOAD   = 13'h0008;
  localparam logic [12:0] ALU_OUT  = 13'h0004;
  localparam logic [12:0] OUT_LOAD = 13'h0002;
  localparam logic [12:0] HALTED   = 13'h0001;
  localparam logic [12:0] NONE     = 13'h0000;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

`ifdef SAP1_CTRL_JMP_EN
  localparam logic [12:0] JMP_T4 = IR_OUT | PC_LOAD;
`else
  localparam logic [12:0] JMP_T4 = NONE;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic       run;
    logic [3:0] op;
    logic [5:0] ts;
    logic [12:0] ctl;
    logic [2:0] alu;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, out_load, halted;
  logic [2:0] alu_op;
  logic [12:0] ctl;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  sap1_controller dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .opcode   (opcode),
    .t_state  (t_state),
    .pc_inc   (pc_inc),
    .pc_out   (pc_out),
    .pc_load  (pc_load),
    .mar_load (mar_load),
    .ram_out  (ram_out),
    .ir_load  (ir_load),
    .ir_out   (ir_out),
    .a_load   (a_load),
    .a_out    (a_out),
    .b_load   (b_load),
    .alu_out  (alu_out),
    .out_load (out_load),
    .halted   (halted),
    .alu_op   (alu_op)
  );

  assign ctl = {pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out,
                a_load, a_out, b_load, alu_out, out_load, halted};

  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, input logic rn, input logic [3:0] op,
                     input logic [5:0] ts, input logic [12:0] c, input logic [2:0] alu);
    vec_t v;
    v.name = name; v.rst = r; v.run = rn; v.op = op;
    v.ts = ts; v.ctl = c; v.alu = alu;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input string name, input logic [3:0] op);
    add({name, ".t1"}, 1'b0, 1'b1, op, S1, PC_OUT | MAR_LOAD, 3'b000);
    add({name, ".t2"}, 1'b0, 1'b1, op, S2, PC_INC, 3'b000);
    add({name, ".t3"}, 1'b0, 1'b1, op, S3, RAM_OUT | IR_LOAD, 3'b000);
  endtask

  task automatic add_instr(input string name, input logic [3:0] op, input logic [12:0] c4,
                           input logic [12:0] c5, input logic [12:0] c6, input logic [2:0] alu6);
    add_fetch(name, op);
    add({name, ".t4"}, 1'b0, 1'b1, op, S4, c4, 3'b000);
    add({name, ".t5"}, 1'b0, 1'b1, op, S5, c5, 3'b000);
    add({name, ".t6"}, 1'b0, 1'b1, op, S6, c6, alu6);
  endtask

  initial begin
    #200000;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: vector run did not complete (%0d vectors applied)", n_vec);
      $finish;
    end
  end

  initial begin
    vec_t exp;
    rst = 1'b1; run = 1'b0; opcode = 4'h0;

    add("reset", 1'b1, 1'b1, 4'h0, S1, NONE, 3'b000);
    add_instr("lda", 4'h0, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, NONE, 3'b000);
    add_instr("sub", 4'h2, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, 3'b001);
    add_fetch("add_stall", 4'h1);
    add("add_stall.t4", 1'b0, 1'b1, 4'h1, S4, IR_OUT | MAR_LOAD, 3'b000);
    for (int i = 0; i < 3; i++) add("add_stall.hold", 1'b0, 1'b0, 4'h1, S5, NONE, 3'b000);
    add("add_stall.t5", 1'b0, 1'b1, 4'h1, S5, RAM_OUT | B_LOAD, 3'b000);
    add("add_stall.t6", 1'b0, 1'b1, 4'h1, S6, ALU_OUT | A_LOAD, 3'b000);
    add_instr("and", 4'h3, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, 3'b010);
    add_instr("or",  4'h4, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, 3'b011);
    add_instr("xor", 4'h5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, 3'b100);
    add_instr("out", 4'he, A_OUT | OUT_LOAD, NONE, NONE, 3'b000);
    add_instr("jmp", 4'h6, JMP_T4, NONE, NONE, 3'b000);
    add_instr("nop7", 4'h7, NONE, NONE, NONE, 3'b000);
    add_instr("nopd", 4'hd, NONE, NONE, NONE, 3'b000);
    add_fetch("sub_rst", 4'h2);
    add("sub_rst.t4", 1'b0, 1'b1, 4'h2, S4, IR_OUT | MAR_LOAD, 3'b000);
    add("sub_rst.t5", 1'b1, 1'b1, 4'h2, S5, NONE, 3'b000);
    add_instr("lda2", 4'h0, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, NONE, 3'b000);
    add_fetch("hlt", 4'hf);
    add("hlt.t4", 1'b0, 1'b1, 4'hf, S4, NONE, 3'b000);
    for (int i = 0; i < 20; i++)
      add("hlt.frozen", 1'b0, (i % 3) != 1, 4'hf, S4, HALTED, 3'b000);
    add("hlt.rst", 1'b1, 1'b0, 4'hf, S4, HALTED, 3'b000);
    add_instr("after_hlt", 4'h1, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, 3'b000);

    @(posedge clk);
    @(negedge clk);
    if (t_state !== S1 || halted !== 1'b0 || ctl !== NONE || alu_op !== 3'b000) begin
      n_bad++;
      $display("FAIL reset state: got t_state=%b halted=%b ctl=%h alu_op=%b, want t_state=%b halted=0 ctl=0 alu_op=000",
               t_state, halted, ctl, alu_op, S1);
    end

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; run = vecs[i].run; opcode = vecs[i].op;
      sb.push_back(vecs[i]);
      @(negedge clk);
      exp = sb.pop_front();
      n_vec++;
      if (t_state !== exp.ts || ctl !== exp.ctl || alu_op !== exp.alu) begin
        n_bad++;
        $display("FAIL %s (vec %0d): got t_state=%b ctl=%h alu_op=%b, want t_state=%b ctl=%h alu_op=%b",
                 exp.name, i, t_state, ctl, alu_op, exp.ts, exp.ctl, exp.alu);
      end
    end

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
